// File: rtl/ws2812_tx_if.sv
// Averager <-> WS2812 serializer link: colour fetch handshake, status and strip line.
// master = averager side, slave = serializer side.
interface ws2812_tx_if;
    logic [23:0] avg_rgb;
    logic        trig;
    logic        nxt;
    logic        t_valid;
    logic        rdy;
    logic        dout;
    logic [7:0]  led_cnt;

    modport master (
        output avg_rgb, trig,
        input  nxt, t_valid, rdy, dout, led_cnt
    );

    modport slave (
        input  avg_rgb, trig,
        output nxt, t_valid, rdy, dout, led_cnt
    );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 single-wire serializer: fetches one colour per LED from the averager, shifts it out
// as GRB MSB-first with fixed pulse widths, then holds the line low for the latch period.
module ws2812_tx #(
    parameter int unsigned NUM_LED = 30,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned T_BIT   = 125,
    parameter int unsigned T0H     = 40,
    parameter int unsigned T1H     = 80,
    parameter int unsigned T_RES   = 30000
) (
    input logic        clk,
    input logic        rst,
    ws2812_tx_if.slave bus
);
    localparam int unsigned TW = $clog2(T_RES + 1);

    localparam logic [TW-1:0] FetchEnd = TW'(RD_LAT);
    localparam logic [TW-1:0] BitEnd   = TW'(T_BIT - 1);
    localparam logic [TW-1:0] ResEnd   = TW'(T_RES - 1);
    localparam logic [TW-1:0] HiZero   = TW'(T0H);
    localparam logic [TW-1:0] HiOne    = TW'(T1H);
    localparam logic [7:0]    LastLed  = 8'(NUM_LED - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StShift, StLatch} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [7:0]    led_q, led_d;
    logic          dout_q, dout_d;
    logic          nxt, t_valid, rdy;

    // Reset lands in LATCH so the strip always sees a full low period before a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLatch;
            timer_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            led_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            led_q   <= led_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        led_d   = led_q;
        unique case (state_q)
            StIdle: begin
                if (bus.trig) begin
                    state_d = StFetch;
                    timer_d = '0;
                    led_d   = '0;
                end
            end
            StFetch: begin
                if (timer_q == FetchEnd) begin
                    state_d = StShift;
                    timer_d = '0;
                    bit_d   = '0;
                    shreg_d = {bus.avg_rgb[15:8], bus.avg_rgb[23:16], bus.avg_rgb[7:0]};
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StShift: begin
                if (timer_q == BitEnd) begin
                    timer_d = '0;
                    if (bit_q == 5'd23) begin
                        if (led_q < LastLed) begin
                            state_d = StFetch;
                            led_d   = led_q + 8'd1;
                        end else begin
                            state_d = StLatch;
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shreg_d = {shreg_q[22:0], 1'b0};
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StLatch: begin
                if (timer_q == ResEnd) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StLatch;
        endcase
    end

    // dout is registered, so its next value is derived from the next-state view of the window.
    always_comb begin
        nxt     = (state_q == StFetch) && (timer_q == '0);
        t_valid = (state_q == StShift);
        rdy     = (state_q == StIdle);
        dout_d  = (state_d == StShift) && (timer_d < (shreg_d[23] ? HiOne : HiZero));
    end

    assign bus.nxt     = nxt;
    assign bus.t_valid = t_valid;
    assign bus.rdy     = rdy;
    assign bus.dout    = dout_q;
    assign bus.led_cnt = led_q;
endmodule

// File: tb/tb_ws2812_tx.sv
// Scoreboard bench for ws2812_tx: an averager model feeds colours on nxt, a line decoder
// rebuilds GRB words from dout and compares them against expectations queued by the stimulus.
module tb_ws2812_tx;
    localparam int unsigned NUM_LED  = 3;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned T_BIT    = 10;
    localparam int unsigned T0H      = 3;
    localparam int unsigned T1H      = 7;
    localparam int unsigned T_RES    = 50;
    localparam int          FrameLen = 779;  // 3 * 243 + 50
    localparam int          LatchLen = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ws2812_tx_if bus ();

    ws2812_tx #(
        .NUM_LED (NUM_LED),
        .RD_LAT  (RD_LAT),
        .T_BIT   (T_BIT),
        .T0H     (T0H),
        .T1H     (T1H),
        .T_RES   (T_RES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] src_q[$];
    logic [31:0] exp_q[$];
    int          nxt_cnt  = 0;
    bit          mon_en   = 1'b0;
    bit          abort_ok = 1'b0;

    // Averager inputs and hand-computed GRB words.
    logic [23:0] col_tab [9] = '{24'hFF0000, 24'h0000FF, 24'hA5C3F0,
                                 24'h123456, 24'hABCDEF, 24'h000001,
                                 24'h00FF00, 24'hFFFFFF, 24'h0F0F0F};
    logic [23:0] grb_tab [9] = '{24'h00FF00, 24'h0000FF, 24'hC3A5F0,
                                 24'h341256, 24'hCDABEF, 24'h000001,
                                 24'hFF0000, 24'hFFFFFF, 24'h0F0F0F};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Averager model: the colour is only valid on the sampling cycle, noise otherwise.
    int          cd = 0;
    logic [23:0] cur = '0;
    always @(negedge clk) begin
        if (mon_en && bus.nxt === 1'b1) begin
            nxt_cnt++;
            if (src_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL nxt_unexpected: got nxt=1, expected no request at %0t", $time);
                cur = '0;
            end else begin
                cur = src_q.pop_front();
            end
            cd = RD_LAT;
            bus.avg_rgb = 24'($urandom);
        end else if (cd > 0) begin
            cd--;
            bus.avg_rgb = (cd == 0) ? cur : 24'($urandom);
        end else begin
            bus.avg_rgb = 24'($urandom);
        end
    end

    // Line decoder.
    int          pos = 0, hcnt = 0, nbits = 0;
    bit          fell = 1'b0, glitch = 1'b0, just_done = 1'b0;
    logic [23:0] word = '0;
    logic [7:0]  widx = '0, last_idx = '0;
    logic [31:0] e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (just_done) begin
                chk("gap_tvalid", 32'(bus.t_valid), 32'd0);
                chk("gap_nxt", 32'(bus.nxt), 32'(last_idx < 8'(NUM_LED - 1)));
                just_done = 1'b0;
            end
            if (bus.t_valid !== 1'b1) chk("dout_idle", 32'(bus.dout), 32'd0);
            if (bus.t_valid === 1'b1) begin
                if (pos == 0 && nbits == 0) widx = bus.led_cnt;
                if (bus.dout === 1'b1) begin
                    if (fell) glitch = 1'b1;
                    hcnt++;
                end else begin
                    fell = 1'b1;
                end
                pos++;
                if (pos == T_BIT) begin
                    chk("bit_glitch", 32'(glitch), 32'd0);
                    chk("bit_high", 32'(hcnt), (hcnt >= 5) ? 32'(T1H) : 32'(T0H));
                    word = {word[22:0], (hcnt >= 5)};
                    nbits++;
                    pos = 0; hcnt = 0; fell = 1'b0; glitch = 1'b0;
                    if (nbits == 24) begin
                        nbits = 0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL word_unexpected: got %06h, expected no word", word);
                        end else begin
                            e = exp_q.pop_front();
                            chk("grb_word", 32'(word), 32'(e[23:0]));
                            chk("led_cnt", 32'(widx), 32'(e[31:24]));
                        end
                        just_done = 1'b1;
                        last_idx  = widx;
                    end
                end
            end else if (pos != 0 || nbits != 0) begin
                if (!abort_ok) chk("tvalid_len", 32'(nbits * T_BIT + pos), 32'(24 * T_BIT));
                pos = 0; hcnt = 0; nbits = 0; fell = 1'b0; glitch = 1'b0;
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        while (bus.rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_rdy: got rdy=%b, expected 1 within 2000 cycles", bus.rdy);
        end
    endtask

    task automatic count_latch(input string name);
        int n = 0;
        while (bus.rdy !== 1'b1 && n < 1000) begin
            chk("latch_quiet", 32'({bus.dout, bus.nxt, bus.t_valid, bus.led_cnt}), 32'd0);
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'(LatchLen));
    endtask

    task automatic load(input int b);
        for (int i = 0; i < 3; i++) begin
            src_q.push_back(col_tab[b + i]);
            exp_q.push_back({8'(i), grb_tab[b + i]});
        end
    endtask

    // Counts rdy-low cycles from the cycle after trig; returns with rdy high.
    task automatic frame_len(input bit busy, output int n);
        n = 0;
        while (bus.rdy !== 1'b1 && n < 2000) begin
            bus.trig = busy && (n == 100 || n == 750);
            n++;
            @(negedge clk);
        end
        bus.trig = 1'b0;
    endtask

    task automatic run_frame(input int b, input bit busy);
        int n;
        int n0;
        wait_rdy();
        load(b);
        n0 = nxt_cnt;
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        chk("start_rdy", 32'(bus.rdy), 32'd0);
        chk("start_nxt", 32'(bus.nxt), 32'd1);
        frame_len(busy, n);
        chk("frame_len", 32'(n), 32'(FrameLen));
        chk("frame_nxt", 32'(nxt_cnt - n0), 32'd3);
        chk("frame_drain", 32'(exp_q.size() + src_q.size()), 32'd0);
    endtask

    task automatic reset_mid();
        int n = 0;
        wait_rdy();
        load(6);
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        while (!(bus.led_cnt === 8'd1 && bus.t_valid === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (5 * T_BIT) @(negedge clk);
        n = 0;
        while (bus.dout !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_dout_high", 32'(bus.dout), 32'd1);
        abort_ok = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_dout", 32'(bus.dout), 32'd0);
        chk("mid_rst_tvalid", 32'(bus.t_valid), 32'd0);
        count_latch("mid_rst_latch");
        exp_q.delete();
        src_q.delete();
        abort_ok = 1'b0;
    endtask

    task automatic back_to_back();
        int n;
        int n0;
        wait_rdy();
        load(3);
        load(0);
        n0 = nxt_cnt;
        bus.trig = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus.rdy !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_len1", 32'(n), 32'(FrameLen));
        @(negedge clk);
        chk("b2b_accept", 32'(bus.rdy), 32'd0);
        n = 0;
        while (bus.rdy !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        bus.trig = 1'b0;
        chk("b2b_len2", 32'(n), 32'(FrameLen));
        @(negedge clk);
        chk("b2b_idle", 32'(bus.rdy), 32'd1);
        chk("b2b_nxt", 32'(nxt_cnt - n0), 32'd6);
        chk("b2b_drain", 32'(exp_q.size() + src_q.size()), 32'd0);
    endtask

    initial begin
        bus.trig    = 1'b0;
        bus.avg_rgb = '0;
        rst         = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_outputs", 32'({bus.dout, bus.nxt, bus.t_valid, bus.rdy, bus.led_cnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_latch("startup_latch");

        // Reset and trigger together: reset wins.
        rst      = 1'b1;
        bus.trig = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.trig = 1'b0;
        chk("rst_trig_rdy", 32'(bus.rdy), 32'd0);
        count_latch("rst_trig_latch");

        run_frame(0, 1'b0);
        run_frame(3, 1'b0);
        run_frame(3, 1'b1);
        reset_mid();
        run_frame(3, 1'b0);
        back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serializes per-LED average colours from `get_average` onto a WS2812-style single-wire LED strip. It is the stage directly downstream of the averager. On a frame trigger it requests one 24-bit colour per LED through the `nxt` pulse. It shifts each colour out as GRB, MSB first, using fixed high/low pulse widths, then holds the line low for the latch/reset period. It reports busy/idle back to the averager through `t_valid` and `rdy`.

## Interface
- `NUM_LED`, 30, LEDs per frame (2·num_h + 2·num_v); legal range 1..255
- `RD_LAT`, 2, cycles from `nxt` pulse to `avg_rgb` being valid for sampling; ≥1
- `T_BIT`, 125, clk cycles per bit (1.25 µs at 100 MHz)
- `T0H`, 40, high cycles for a 0 bit
- `T1H`, 80, high cycles for a 1 bit; constraint 0 < `T0H` < `T1H` < `T_BIT`
- `T_RES`, 30000, low cycles for the latch/reset period (300 µs)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `avg_rgb`  in  24  colour from averager: [23:16]=R, [15:8]=G, [7:0]=B
- `trig`  in  1  frame start pulse from averager
- `nxt`  out  1  one-cycle request for the next LED colour
- `t_valid`  out  1  high while a 24-bit word is being shifted
- `rdy`  out  1  high only in IDLE; a trigger is accepted only while `rdy` is high
- `dout`  out  1  strip data line, registered
- `led_cnt`  out  8  index of the LED currently being fetched or shifted

## Operation
- States:
  - IDLE: waits for a trigger.
  - FETCH: pulses `nxt`, then waits `RD_LAT` cycles.
  - SHIFT: sends 24 bits.
  - LATCH: holds `dout` low for `T_RES` cycles.
- Transitions:
  - IDLE & `trig` → FETCH, with `led_cnt`=0.
  - FETCH → SHIFT once the word is latched.
  - SHIFT, after bit 24:
    - `led_cnt` < `NUM_LED`-1 → FETCH, with `led_cnt`+1.
    - otherwise → LATCH.
  - LATCH, after `T_RES` cycles → IDLE.
- Word latch: shift register ← {G, R, B} = {`avg_rgb`[15:8], `avg_rgb`[23:16], `avg_rgb`[7:0]}. Bit 23 is sent first.
- Bit encoding: `dout`=1 for the first `T0H` cycles (bit value 0) or the first `T1H` cycles (bit value 1) of the `T_BIT`-cycle window. `dout`=0 for the rest of the window.
- `dout`=0 in IDLE, FETCH and LATCH. The inter-LED gap of `RD_LAT`+1 low cycles is acceptable: it is far below the strip's reset threshold.
- `trig` outside IDLE is ignored; it is neither queued nor counted.
- `avg_rgb` is don't-care except on the sample cycle.
- Timer width is clog2(`T_RES`+1) bits and is shared by bit timing and LATCH. The bit counter is 5 bits.
- `rst` forces LATCH with the timer cleared, from any state and including mid-bit. The strip therefore sees a full low reset before any new frame.

## Timing
- Reset values: `dout`=0, `nxt`=0, `t_valid`=0, `rdy`=0, `led_cnt`=0, state=LATCH.
- `rdy` first rises `T_RES` cycles after the last `rst` cycle.
- Frame start and first bit:
  - `trig` sampled high at cycle t in IDLE → `rdy`=0 at t+1 and `nxt`=1 for exactly cycle t+1.
  - `avg_rgb` is sampled at the rising edge ending cycle t+1+`RD_LAT`.
  - `dout` and `t_valid` go high at cycle t+2+`RD_LAT` (first bit).
- `t_valid` stays high for exactly 24·`T_BIT` cycles per LED.
- Between LEDs: the next `nxt` pulse occurs on the first cycle after the 24th bit window. Same latency thereafter.
- Frame length: `NUM_LED`·(1+`RD_LAT`+24·`T_BIT`) + `T_RES` cycles from the cycle after `trig` until `rdy` returns high.
- Boundary cases:
  - `trig` in the same cycle `rdy` rises: IDLE is entered that cycle, so the trigger is accepted.
  - `rst` and `trig` together: reset wins.

## Test plan
Bench parameters: `NUM_LED`=3, `RD_LAT`=2, `T_BIT`=10, `T0H`=3, `T1H`=7, `T_RES`=50.

- Reset/startup: assert `rst` 2 cycles, then release → `dout`=0 throughout and `rdy` rises exactly 50 cycles after release. All other outputs stay 0.
- Single word encoding: `avg_rgb`=0xFF0000, 1 LED:
  - Bits 23..16 (G) are 0-bits: 3 high / 7 low each.
  - Bits 15..8 (R) are 1-bits: 7 high / 3 low.
  - Bits 7..0 (B) are 0-bits.
  - Bench decoder reads 0x00FF00.
- Full frame: averager model returns 0x123456, 0xABCDEF, 0x000001 → 3 `nxt` pulses. Decoded GRB words are 0x341256, 0xCDABEF, 0x000001. `led_cnt` steps 0,1,2. `rdy` returns after 3·243+50 = 779 cycles.
- Busy trigger: pulse `trig` mid-SHIFT and mid-LATCH → no extra `nxt`, and the frame length is unchanged.
- Reset mid-shift: assert `rst` during bit 5 of LED 1 while `dout`=1 → `dout`=0 the next cycle, then `rdy` rises 50 cycles after release. A following `trig` runs a clean 3-LED frame.
- Back-to-back: hold `trig` high continuously → a new frame starts on the same cycle `rdy` rises. No LATCH is shortened.
